// File: rtl/simd_pkg.sv
// simd_pkg: shared sizes, vector types and lane-merge helper for the SIMD vector register file
package simd_pkg;
  localparam int ELEMENTS_PER_REGISTER = 4;
  localparam int ELEM_WIDTH = 32;
  localparam int NUM_VREGS = 8;
  localparam int VR_WIDTH = ELEMENTS_PER_REGISTER * ELEM_WIDTH;
  localparam int IDX_W = $clog2(NUM_VREGS);
  localparam int CNT_W = IDX_W + 1;
  typedef logic [IDX_W-1:0] vreg_idx_t;
  typedef logic [VR_WIDTH-1:0] vec_t;
  typedef logic [ELEMENTS_PER_REGISTER-1:0] lane_mask_t;
  localparam vec_t ZERO_VECTOR = '0;
  function automatic vec_t merge_lanes(vec_t old_v, vec_t new_v, lane_mask_t m);
    vec_t r;
    r = old_v;
    for (int i = 0; i < ELEMENTS_PER_REGISTER; i++)
      if (m[i]) r[i*ELEM_WIDTH +: ELEM_WIDTH] = new_v[i*ELEM_WIDTH +: ELEM_WIDTH];
    return r;
  endfunction
endpackage

// File: rtl/simd_vrf_scoreboard.sv
// simd_vrf_scoreboard: busy bits, issue accept, outstanding count, sticky wb error (VRF_BYPASS_EN lets a same-cycle writeback clear the hazard)
module simd_vrf_scoreboard
  import simd_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 issue_valid,
  input  logic [IDX_W-1:0]     issue_ra1,
  input  logic [IDX_W-1:0]     issue_ra2,
  input  logic [IDX_W-1:0]     issue_rd,
  input  logic                 wb_valid,
  input  logic [IDX_W-1:0]     wb_rd,
  output logic                 issue_ready,
  output logic [NUM_VREGS-1:0] busy_vec,
  output logic [CNT_W-1:0]     outstanding,
  output logic                 wb_unexpected
);
  logic [NUM_VREGS-1:0] busy_q, busy_d, busy_eff, wb_clr;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic wb_unexpected_q, wb_unexpected_d;
  always_comb begin
    wb_clr = wb_valid ? NUM_VREGS'(1) << wb_rd : '0;
`ifdef VRF_BYPASS_EN
    busy_eff = busy_q & ~wb_clr;
`else
    busy_eff = busy_q;
`endif
    issue_ready = !reset && issue_valid && !busy_eff[issue_ra1] && !busy_eff[issue_ra2] && !busy_eff[issue_rd];
    busy_d = (busy_q & ~wb_clr) | (issue_ready ? NUM_VREGS'(1) << issue_rd : '0);
    wb_unexpected_d = wb_unexpected_q | (wb_valid & ~busy_q[wb_rd]);
    outstanding_d = '0;
    for (int i = 0; i < NUM_VREGS; i++) outstanding_d = outstanding_d + CNT_W'(busy_d[i]);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
      outstanding_q <= '0;
      wb_unexpected_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      outstanding_q <= outstanding_d;
      wb_unexpected_q <= wb_unexpected_d;
    end
  end
  assign busy_vec = busy_q;
  assign outstanding = outstanding_q;
  assign wb_unexpected = wb_unexpected_q;
endmodule

// File: rtl/simd_vrf.sv
// simd_vrf: vector register file with masked writeback and issue scoreboard (VRF_BYPASS_EN adds writeback-to-read forwarding)
module simd_vrf
  import simd_pkg::*;
(
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             issue_valid,
  input  logic [IDX_W-1:0]                 issue_ra1,
  input  logic [IDX_W-1:0]                 issue_ra2,
  input  logic [IDX_W-1:0]                 issue_rd,
  output logic                             issue_ready,
  output logic [VR_WIDTH-1:0]              rd1,
  output logic [VR_WIDTH-1:0]              rd2,
  input  logic                             wb_valid,
  input  logic [IDX_W-1:0]                 wb_rd,
  input  logic [VR_WIDTH-1:0]              wd3,
  input  logic [ELEMENTS_PER_REGISTER-1:0] wb_lane_mask,
  output logic [NUM_VREGS-1:0]             busy_vec,
  output logic [CNT_W-1:0]                 outstanding,
  output logic                             wb_unexpected
);
  vec_t vr_q [NUM_VREGS];
  vec_t vr_d [NUM_VREGS];
  vec_t wb_merged;
  always_comb begin
    wb_merged = merge_lanes(vr_q[wb_rd], wd3, wb_lane_mask);
    vr_d = vr_q;
    if (wb_valid) vr_d[wb_rd] = wb_merged;
`ifdef VRF_BYPASS_EN
    rd1 = wb_valid && issue_ra1 == wb_rd ? wb_merged : vr_q[issue_ra1];
    rd2 = wb_valid && issue_ra2 == wb_rd ? wb_merged : vr_q[issue_ra2];
`else
    rd1 = vr_q[issue_ra1];
    rd2 = vr_q[issue_ra2];
`endif
  end
  always_ff @(posedge clk) begin
    if (reset) vr_q <= '{default: ZERO_VECTOR};
    else vr_q <= vr_d;
  end
  simd_vrf_scoreboard u_sb (
    .clk(clk),
    .reset(reset),
    .issue_valid(issue_valid),
    .issue_ra1(issue_ra1),
    .issue_ra2(issue_ra2),
    .issue_rd(issue_rd),
    .wb_valid(wb_valid),
    .wb_rd(wb_rd),
    .issue_ready(issue_ready),
    .busy_vec(busy_vec),
    .outstanding(outstanding),
    .wb_unexpected(wb_unexpected)
  );
endmodule

// File: doc/simd_vrf.md
Name: simd_vrf

Overview:
Vector register file and issue scoreboard for the SIMD path. It is the other end of the SIMD execution stage's datapath. It supplies operand vectors rd1/rd2 to the execution lanes and accepts their registered result vector on the writeback port (wd3). A per-register busy scoreboard stalls issue on RAW and WAW hazards until the result for a pending destination is written back.

Parameters:
ELEMENTS_PER_REGISTER, 4, elements per vector (lanes)
ELEM_WIDTH, 32, bits per element
NUM_VREGS, 8, number of vector registers (power of 2, >=2)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
issue_valid  input  1  decoder presents a vector op this cycle
issue_ra1  input  $clog2(NUM_VREGS)  source register A
issue_ra2  input  $clog2(NUM_VREGS)  source register B
issue_rd  input  $clog2(NUM_VREGS)  destination register
issue_ready  output  1  op accepted this cycle (combinational)
rd1  output  ELEMENTS_PER_REGISTER*ELEM_WIDTH  operand A vector (combinational read of ra1)
rd2  output  ELEMENTS_PER_REGISTER*ELEM_WIDTH  operand B vector (combinational read of ra2)
wb_valid  input  1  result vector valid
wb_rd  input  $clog2(NUM_VREGS)  writeback destination
wd3  input  ELEMENTS_PER_REGISTER*ELEM_WIDTH  result vector
wb_lane_mask  input  ELEMENTS_PER_REGISTER  per-element write enable; bit i covers bits [ELEM_WIDTH*(i+1)-1 : ELEM_WIDTH*i]
busy_vec  output  NUM_VREGS  current scoreboard, bit r = vr[r] pending
outstanding  output  $clog2(NUM_VREGS)+1  count of set busy bits
wb_unexpected  output  1  sticky error flag

Behaviour:
- Reset: all registers zero; busy_vec=0; outstanding=0; wb_unexpected=0. issue_ready=0 while reset is high. A writeback during reset is ignored. Reset mid-operation discards all pending hazards.
- Storage: NUM_VREGS x VR_WIDTH array. VR_WIDTH = ELEMENTS_PER_REGISTER*ELEM_WIDTH. Element 0 sits in the LSBs. Reads are asynchronous. Writes happen on the rising edge.
- Issue accept condition: issue_ready = issue_valid & !busy[ra1] & !busy[ra2] & !busy[rd]. The check uses registered busy, apart from the optional bypass below.
- On accept: set busy[rd] next cycle. rd1/rd2 are valid in the accept cycle. ra1==rd and ra1==ra2 are legal.
- issue_valid with !issue_ready: no state change. The decoder holds the op and retries.
- Writeback: when wb_valid, write the masked elements of wd3 into vr[wb_rd] and clear busy[wb_rd]. Unmasked elements keep their old value. A zero mask writes nothing but still clears busy.
- wb_valid to a non-busy register: the write still happens, and wb_unexpected sets and stays set until reset.
- Same-cycle accept and writeback to different registers: both take effect.
- Same-cycle accept and writeback to the same register: set wins, so busy stays 1. This is reachable only with the bypass feature.
- outstanding is the registered popcount of the next busy state; its range is 0..NUM_VREGS.
- No read-during-write forwarding by default. A read in the writeback cycle returns the old data, but the scoreboard already blocks that read.

Optional Feature:
VRF_BYPASS_EN.
- Defined: a writeback in the same cycle counts as clearing the hazard. busy_eff[r] = busy[r] & !(wb_valid & wb_rd==r), and issue_ready uses busy_eff.
- Defined: rd1/rd2 forward the merged value (old data with masked wd3 elements applied) when ra1/ra2 == wb_rd under wb_valid. This removes one stall cycle per dependent op.
- Undefined: registered busy only, with a 1-cycle stall after writeback.

Decomposition:
- Package simd_pkg holds:
  - ELEMENTS_PER_REGISTER, ELEM_WIDTH and NUM_VREGS defaults
  - VR_WIDTH
  - vreg_idx_t (register index type)
  - vec_t (VR_WIDTH vector type)
  - lane_mask_t
  - ZERO_VECTOR
- One natural sub-module, simd_vrf_scoreboard. It holds the busy bits, the outstanding counter, the accept logic and wb_unexpected. The array and forwarding muxes stay in the top.

Test Plan:
- Reset, then read v0..v7 -> all zero; busy_vec=0; outstanding=0; issue_ready=1 for issue ra1=1 ra2=2 rd=3.
- Issue rd=3 accepted; next cycle issue ra1=3 -> issue_ready=0. Then wb_rd=3, wd3=0x4_3_2_1 per element, mask=4'hF -> without VRF_BYPASS_EN ready rises the following cycle and rd1=elements {4,3,2,1}. With it, ready=1 and rd1 is forwarded in the writeback cycle.
- WAW: rd=5 pending, second issue rd=5 -> stalls. Writeback wb_rd=5 -> busy clears and the retry is accepted.
- Masked write: vr2=all 0xFFFFFFFF, wb_rd=2, wd3=0, mask=4'b0101 -> vr2 = {0xFFFFFFFF,0,0xFFFFFFFF,0} (element 3..0).
- Writeback to non-busy v6 -> data written, wb_unexpected=1 and held until reset. Reset with v1/v4 busy -> busy_vec=0, outstanding=0, registers zero.
- Fill: issue rd=0..7 back-to-back with distinct sources free -> outstanding reaches 8 and any further issue stalls. Same-cycle accept rd=1 plus writeback wb_rd=0 -> busy_vec[1]=1 and busy_vec[0]=0.
